// File: rtl/ctrl_multiciclo_pkg.sv
// rtl/ctrl_multiciclo_pkg.sv - shared constants and types for the multicycle RV32I control
// Purpose: opcode constants, FSM state encoding, PC-source and writeback-source
// codes, and the DECODE dispatch function.
// Ports: none (package).
package ctrl_multiciclo_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [1:0] PC_NORMAL = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;

  // State that follows DECODE for a given opcode; anything unknown traps.
  function automatic state_t decode_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE: return ST_MEMADDR;
      OPC_RTYPE:           return ST_EXEC_R;
      OPC_OPIMM:           return ST_EXEC_I;
      OPC_BRANCH:          return ST_BRANCH;
      OPC_JAL:             return ST_JAL;
      OPC_JALR:            return ST_JALR;
      OPC_LUI:             return ST_LUI;
      OPC_AUIPC:           return ST_AUIPC;
      default:             return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_multiciclo_saidas.sv
// rtl/ctrl_multiciclo_saidas.sv - combinational state-to-control-signal decode
// Purpose: Moore decode of the FSM state; only oPCWrite/oEscreveIR also look at
// iMemReady (FETCH) and iBrTaken (BRANCH).
// Ports: iEstado, iMemReady, iBrTaken in; oOrigPC, oPCWrite, oEscreveIR, oLeMem,
// oEscreveMem, oIouD, oEscreveReg, oMem2Reg, oOrigAULA_A, oOrigAULA_B, oALUOp out.
module ctrl_saidas
  import ctrl_multiciclo_pkg::*;
(
  input  state_t     iEstado,
  input  logic       iMemReady,
  input  logic       iBrTaken,
  output logic [1:0] oOrigPC,
  output logic       oPCWrite,
  output logic       oEscreveIR,
  output logic       oLeMem,
  output logic       oEscreveMem,
  output logic       oIouD,
  output logic       oEscreveReg,
  output logic [1:0] oMem2Reg,
  output logic [1:0] oOrigAULA_A,
  output logic [1:0] oOrigAULA_B,
  output logic [1:0] oALUOp
);

  always_comb begin
    oOrigPC     = PC_NORMAL;
    oPCWrite    = 1'b0;
    oEscreveIR  = 1'b0;
    oLeMem      = 1'b0;
    oEscreveMem = 1'b0;
    oIouD       = 1'b0;
    oEscreveReg = 1'b0;
    oMem2Reg    = WB_ALUOUT;
    oOrigAULA_A = 2'b00;
    oOrigAULA_B = 2'b00;
    oALUOp      = 2'b00;
    case (iEstado)
      ST_FETCH: begin
        oLeMem      = 1'b1;
        oOrigAULA_B = 2'b01;
        oEscreveIR  = iMemReady;
        oPCWrite    = iMemReady;
      end
      ST_DECODE: begin
        oOrigAULA_A = 2'b10;
        oOrigAULA_B = 2'b10;
      end
      ST_MEMADDR: begin
        oOrigAULA_A = 2'b01;
        oOrigAULA_B = 2'b10;
      end
      ST_MEMREAD: begin
        oLeMem = 1'b1;
        oIouD  = 1'b1;
      end
      ST_MEMWB: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = WB_MDR;
      end
      ST_MEMWRITE: begin
        oEscreveMem = 1'b1;
        oIouD       = 1'b1;
      end
      ST_EXEC_R: begin
        oOrigAULA_A = 2'b01;
        oALUOp      = 2'b10;
      end
      ST_EXEC_I: begin
        oOrigAULA_A = 2'b01;
        oOrigAULA_B = 2'b10;
        oALUOp      = 2'b10;
      end
      ST_ALUWB: begin
        oEscreveReg = 1'b1;
      end
      ST_BRANCH: begin
        oOrigAULA_A = 2'b01;
        oALUOp      = 2'b01;
        oOrigPC     = PC_BRANCH;
        oPCWrite    = iBrTaken;
      end
      ST_JAL: begin
        oOrigPC     = PC_JAL;
        oPCWrite    = 1'b1;
        oEscreveReg = 1'b1;
        oMem2Reg    = WB_PC;
      end
      ST_JALR: begin
        oOrigAULA_A = 2'b01;
        oOrigAULA_B = 2'b10;
        oOrigPC     = PC_JALR;
        oPCWrite    = 1'b1;
        oEscreveReg = 1'b1;
        oMem2Reg    = WB_PC;
      end
      ST_LUI: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = WB_IMM;
      end
      ST_AUIPC: begin
        // ALUOut already holds PCold+imm from DECODE.
        oEscreveReg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_multiciclo.sv
// rtl/ctrl_multiciclo.sv - multicycle RV32I control FSM top level
// Purpose: state register, load/store bit captured in DECODE, sticky illegal
// flag and retired-instruction counter; output decode lives in ctrl_saidas.
// Ports: iCLK, iRST_n, iOpcode, iBrTaken, iMemReady in; PC/IR/memory/regfile/ALU
// control out, oIllegal, oInstret (CNT_W), oEstado (debug state).
module ctrl_multiciclo
  import ctrl_multiciclo_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic [6:0]       iOpcode,
  input  logic             iBrTaken,
  input  logic             iMemReady,
  output logic [1:0]       oOrigPC,
  output logic             oPCWrite,
  output logic             oEscreveIR,
  output logic             oLeMem,
  output logic             oEscreveMem,
  output logic             oIouD,
  output logic             oEscreveReg,
  output logic [1:0]       oMem2Reg,
  output logic [1:0]       oOrigAULA_A,
  output logic [1:0]       oOrigAULA_B,
  output logic [1:0]       oALUOp,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oInstret,
  output logic [3:0]       oEstado
);

  state_t           r_estado;
  state_t           w_prox;
  logic             r_is_store;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_pcwrite;
  logic             w_escreve_ir;

  always_comb begin
    w_prox   = r_estado;
    w_retire = 1'b0;
    case (r_estado)
      ST_FETCH:    if (iMemReady) w_prox = ST_DECODE;
      ST_DECODE:   w_prox = decode_opcode(iOpcode);
      ST_MEMADDR:  w_prox = r_is_store ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (iMemReady) w_prox = ST_MEMWB;
      ST_MEMWRITE: begin
        if (iMemReady) begin
          w_prox   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_EXEC_R, ST_EXEC_I: w_prox = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR, ST_LUI, ST_AUIPC: begin
        w_prox   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_TRAP: w_prox = ST_TRAP;
      default: w_prox = ST_TRAP;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_estado   <= ST_FETCH;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_estado <= w_prox;
      // Opcode bit 5 separates store (0100011) from load (0000011).
      if (r_estado == ST_DECODE) r_is_store <= iOpcode[5];
      if (w_prox == ST_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  ctrl_saidas u_saidas (
    .iEstado     (r_estado),
    .iMemReady   (iMemReady),
    .iBrTaken    (iBrTaken),
    .oOrigPC     (oOrigPC),
    .oPCWrite    (w_pcwrite),
    .oEscreveIR  (w_escreve_ir),
    .oLeMem      (oLeMem),
    .oEscreveMem (oEscreveMem),
    .oIouD       (oIouD),
    .oEscreveReg (oEscreveReg),
    .oMem2Reg    (oMem2Reg),
    .oOrigAULA_A (oOrigAULA_A),
    .oOrigAULA_B (oOrigAULA_B),
    .oALUOp      (oALUOp)
  );

  // FETCH enables depend on iMemReady; block them while reset is held.
  assign oPCWrite   = w_pcwrite & iRST_n;
  assign oEscreveIR = w_escreve_ir & iRST_n;
  assign oIllegal   = r_illegal;
  assign oInstret   = r_instret;
  assign oEstado    = r_estado;

endmodule
